uart_periph: RTL and testbench
==============================

UART_PERIPH -- requirements
Module: uart_periph

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, SHALL set clock cycles per UART bit (even, >=4).
REQ-002 Parameter BASE_ADDR, default 32'h0000_0400, SHALL set the register block base (word-aligned).
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-005 ADDR  input  32  CPU byte address.
REQ-006 WD  input  32  CPU write data.
REQ-007 WE  input  1  CPU store strobe, one cycle per access.
REQ-008 RE  input  1  CPU load strobe, one cycle per access.
REQ-009 RD  output  32  CPU read data.
REQ-010 rx  input  1  serial receive line, asynchronous, idle high.
REQ-011 tx  output  1  serial transmit line, idle high.

Function
REQ-012 Register map SHALL be: BASE+0 TXDATA (write-only), BASE+4 RXDATA (read-only), BASE+8 STATUS; all other addresses SHALL have no effect on writes and SHALL read 0.
REQ-013 RD SHALL be combinational from ADDR: RXDATA -> {24'b0, rx_data}; STATUS -> {28'b0, overrun, frame_err, rx_valid, tx_busy} in bits [3:0].
REQ-014 WE to TXDATA with tx_busy=0 SHALL latch WD[7:0] and set tx_busy at that edge; WE to TXDATA with tx_busy=1 SHALL be ignored.
REQ-015 TX frame SHALL start at the edge after the write: start bit 0, 8 data bits LSB-first, stop bit 1, each held exactly CLKS_PER_BIT cycles.
REQ-016 tx_busy SHALL clear at the end of the stop bit (10*CLKS_PER_BIT cycles after the frame starts); a new write SHALL be accepted in that same cycle.
REQ-017 TX FSM states SHALL be IDLE -> START -> DATA(bit index 0..7) -> STOP -> IDLE.
REQ-018 rx SHALL pass a 2-flop synchronizer before any use.
REQ-019 RX FSM states SHALL be IDLE -> START -> DATA -> STOP -> IDLE; IDLE -> START on a synchronized falling edge.
REQ-020 START SHALL resample at CLKS_PER_BIT/2 cycles; if high, return to IDLE (false start, no flags change).
REQ-021 Data bits SHALL be sampled every CLKS_PER_BIT cycles after the start mid-point, LSB-first; the stop bit sampled likewise.
REQ-022 Stop sample 0 SHALL set sticky frame_err and discard the byte; stop sample 1 SHALL deliver the byte.
REQ-023 Delivery with rx_valid=0 SHALL load rx_data and set rx_valid at the edge after the stop sample.
REQ-024 Delivery with rx_valid=1 and no same-cycle pop SHALL discard the new byte and set sticky overrun.
REQ-025 RE to RXDATA SHALL clear rx_valid at that edge; pop and delivery in the same cycle SHALL load the new byte, leave rx_valid=1, and not set overrun.
REQ-026 WE to STATUS SHALL clear frame_err if WD[2]=1 and overrun if WD[3]=1 (write-1-to-clear); a same-cycle set SHALL win over clear.
REQ-027 RX and TX SHALL operate fully independently and concurrently.

Reset
REQ-028 While reset=0 at an edge: tx=1, tx_busy=0, rx_valid=0, rx_data=0, frame_err=0, overrun=0, both FSMs IDLE, counters 0, synchronizer flops 1.
REQ-029 Reset asserted mid-frame SHALL abort both directions with no partial byte delivered; tx SHALL be 1 from the next edge.

Structure
REQ-030 Shared package uart_pkg SHALL hold register offsets, STATUS bit positions, and the TX/RX state enum typedefs.
REQ-031 Receive logic (synchronizer, RX FSM, bit counter) SHALL be one sub-module uart_rx_core; TX and register decode SHALL stay in uart_periph.

Verification (CLKS_PER_BIT=16)
REQ-032 Write 0x55 to TXDATA -> tx low 16 cycles from next edge, then 1,0,1,0,1,0,1,0 at 16 cycles each, stop high; tx_busy=1 for exactly 160 cycles.
REQ-033 Drive rx frame 0xA3 -> rx_valid=1 one edge after stop mid-sample; RE at RXDATA returns 0x000000A3 and rx_valid=0 next cycle.
REQ-034 Two frames 0x11, 0x22 without reading -> STATUS=0x00000A (overrun=1, rx_valid=1); RXDATA=0x11.
REQ-035 rx low pulse of 4 cycles -> no delivery, STATUS unchanged.
REQ-036 Frame 0x3C with stop bit 0 -> frame_err=1, rx_valid=0; write 0x4 to STATUS -> frame_err=0.
REQ-037 Assert reset 50 cycles into a TX frame -> tx=1 and tx_busy=0 on the next edge; subsequent write transmits normally.

Source files
------------

// File: rtl/uart_pkg.sv
// UART peripheral shared definitions: register offsets,
// STATUS bit positions and TX/RX state encodings.
package uart_pkg;

  localparam logic [31:0] TXDATA_OFS = 32'h0;
  localparam logic [31:0] RXDATA_OFS = 32'h4;
  localparam logic [31:0] STATUS_OFS = 32'h8;

  localparam int ST_TX_BUSY   = 0;
  localparam int ST_RX_VALID  = 1;
  localparam int ST_FRAME_ERR = 2;
  localparam int ST_OVERRUN   = 3;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronizer, start/data/stop FSM.
// Ports: clk, reset (sync, low), rx in; byte_stb/byte_data/frame_stb out.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_stb,
  output logic [7:0] byte_data,
  output logic       frame_stb
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     state;
  logic          s1;
  logic          s2;
  logic          prev;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;

  assign byte_data = sh;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= RX_IDLE;
      s1        <= 1'b1;
      s2        <= 1'b1;
      prev      <= 1'b1;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      byte_stb  <= 1'b0;
      frame_stb <= 1'b0;
    end else begin
      s1        <= rx;
      s2        <= s1;
      prev      <= s2;
      byte_stb  <= 1'b0;
      frame_stb <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (prev && !s2) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            idx <= '0;
            // line back high at mid-start: glitch, not a frame
            state <= s2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == LAST) begin
            cnt <= '0;
            sh  <= {s2, sh[7:1]};
            if (idx == 3'd7) state <= RX_STOP;
            else idx <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == LAST) begin
            cnt       <= '0;
            state     <= RX_IDLE;
            byte_stb  <= s2;
            frame_stb <= !s2;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_periph.sv
// Memory-mapped UART: TXDATA/RXDATA/STATUS registers, TX FSM.
// Ports: clk, reset, ADDR/WD/WE/RE/RD CPU bus, rx/tx serial lines.
module uart_periph
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ADDR,
  input  logic [31:0] WD,
  input  logic        WE,
  input  logic        RE,
  output logic [31:0] RD,
  input  logic        rx,
  output logic        tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic sel_tx;
  logic sel_rx;
  logic sel_st;
  assign sel_tx = (ADDR == BASE_ADDR + TXDATA_OFS);
  assign sel_rx = (ADDR == BASE_ADDR + RXDATA_OFS);
  assign sel_st = (ADDR == BASE_ADDR + STATUS_OFS);

  logic unused_wd;
  assign unused_wd = ^WD[31:8];

  tx_state_t     tx_state;
  logic          tx_busy;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_sh;
  logic          tx_wr;
  assign tx_wr = WE && sel_tx && !tx_busy;

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_sh    <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_wr) begin
            tx_sh    <= WD[7:0];
            tx_busy  <= 1'b1;
            tx       <= 1'b0;
            tx_cnt   <= '0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == LAST) begin
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx       <= tx_sh[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == LAST) begin
            tx_cnt <= '0;
            tx_sh  <= {1'b0, tx_sh[7:1]};
            if (tx_idx == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx     <= tx_sh[1];
              tx_idx <= tx_idx + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == LAST) begin
            tx_cnt   <= '0;
            tx_busy  <= 1'b0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  logic       byte_stb;
  logic [7:0] byte_data;
  logic       frame_stb;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .byte_stb (byte_stb),
    .byte_data(byte_data),
    .frame_stb(frame_stb)
  );

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       frame_err;
  logic       overrun;
  logic       pop;
  logic       st_wr;
  assign pop   = RE && sel_rx;
  assign st_wr = WE && sel_st;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // a pop in the same cycle frees the slot for the new byte
      if (byte_stb && (!rx_valid || pop)) begin
        rx_data  <= byte_data;
        rx_valid <= 1'b1;
      end else if (pop) begin
        rx_valid <= 1'b0;
      end
      if (frame_stb) frame_err <= 1'b1;
      else if (st_wr && WD[ST_FRAME_ERR]) frame_err <= 1'b0;
      if (byte_stb && rx_valid && !pop) overrun <= 1'b1;
      else if (st_wr && WD[ST_OVERRUN]) overrun <= 1'b0;
    end
  end

  always_comb begin
    RD = '0;
    if (sel_rx) begin
      RD[7:0] = rx_data;
    end else if (sel_st) begin
      RD[ST_TX_BUSY]   = tx_busy;
      RD[ST_RX_VALID]  = rx_valid;
      RD[ST_FRAME_ERR] = frame_err;
      RD[ST_OVERRUN]   = overrun;
    end
  end

endmodule

// File: tb/tb_uart_periph.sv
// Self-checking bench for uart_periph: register table,
// TX waveform/scoreboard, RX frames, errors and reset abort.
`timescale 1ns/1ps
module tb_uart_periph;

  localparam int          CPB  = 16;
  localparam logic [31:0] BASE = 32'h0000_0400;
  localparam logic [31:0] A_TX = BASE + 32'h0;
  localparam logic [31:0] A_RX = BASE + 32'h4;
  localparam logic [31:0] A_ST = BASE + 32'h8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ADDR;
  logic [31:0] WD;
  logic        WE;
  logic        RE;
  logic [31:0] RD;
  logic        rx;
  logic        tx;

  int checks = 0;
  int errors = 0;

  logic [7:0] txq[$];
  logic [7:0] rxq[$];

  always #5 clk = ~clk;

  uart_periph #(
    .CLKS_PER_BIT(CPB),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .ADDR (ADDR),
    .WD   (WD),
    .WE   (WE),
    .RE   (RE),
    .RD   (RD),
    .rx   (rx),
    .tx   (tx)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
    string       name;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ADDR = a;
    WD   = d;
    WE   = 1'b1;
    @(posedge clk);
    #1;
    WE   = 1'b0;
    ADDR = A_ST;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    ADDR = a;
    #1;
    d = RD;
  endtask

  task automatic pop_read(output logic [31:0] d);
    @(negedge clk);
    ADDR = A_RX;
    RE   = 1'b1;
    #1;
    d = RD;
    @(posedge clk);
    #1;
    RE   = 1'b0;
    ADDR = A_ST;
  endtask

  task automatic wait_status(input logic [31:0] m, input string nm);
    logic [31:0] d;
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      peek(A_ST, d);
      if ((d & m) != 0) ok = 1'b1;
    end
    check(nm, {31'b0, ok}, 32'd1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic tx_frame(input logic [7:0] b, input bit poke,
                          input string nm);
    int mism = 0;
    int busy = 0;
    logic [7:0] dec = '0;
    logic [7:0] exp_b;
    logic exp_t;
    txq.push_back(b);
    bus_write(A_TX, {24'b0, b});
    for (int i = 0; i < 170; i++) begin
      @(negedge clk);
      if (poke && i == 21) begin
        WE   = 1'b0;
        ADDR = A_ST;
      end
      #1;
      if (i < 16) exp_t = 1'b0;
      else if (i < 144) exp_t = b[(i - 16) / 16];
      else exp_t = 1'b1;
      if (tx !== exp_t) mism++;
      if (i >= 16 && i < 144 && (i % 16) == 8) dec[(i - 16) / 16] = tx;
      busy += int'(RD[0]);
      if (poke && i == 20) begin
        ADDR = A_TX;
        WD   = 32'hFF;
        WE   = 1'b1;
      end
    end
    check({nm, "_wave"}, mism, 0);
    check({nm, "_busy_cycles"}, busy, 160);
    exp_b = txq.pop_front();
    check({nm, "_decoded"}, {24'b0, dec}, {24'b0, exp_b});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[$];
    logic [31:0] d;
    logic [7:0] e;

    reset = 1'b0;
    rx    = 1'b1;
    ADDR  = '0;
    WD    = '0;
    WE    = 1'b0;
    RE    = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_tx", {31'b0, tx}, 32'd1);
    reset = 1'b1;

    vt.push_back('{0, A_ST, 0, 32'h0, "rst_status"});
    vt.push_back('{0, A_RX, 0, 32'h0, "rst_rxdata"});
    vt.push_back('{0, A_TX, 0, 32'h0, "txdata_reads0"});
    vt.push_back('{0, BASE + 32'hC, 0, 32'h0, "unmapped_c"});
    vt.push_back('{0, 32'h0, 0, 32'h0, "unmapped_0"});
    vt.push_back('{1, BASE + 32'hC, 32'hFF, 0, ""});
    vt.push_back('{1, BASE + 32'h10, 32'h55, 0, ""});
    vt.push_back('{0, A_ST, 0, 32'h0, "unmapped_wr_noeff"});
    vt.push_back('{1, A_ST, 32'hF, 0, ""});
    vt.push_back('{0, A_ST, 0, 32'h0, "status_w1c_idle"});
    foreach (vt[i]) begin
      if (vt[i].wr) bus_write(vt[i].addr, vt[i].wd);
      else begin
        peek(vt[i].addr, d);
        check(vt[i].name, d, vt[i].exp);
      end
    end
    check("tx_idle_high", {31'b0, tx}, 32'd1);

    tx_frame(8'h55, 1'b1, "tx55");

    rxq.push_back(8'hA3);
    send_rx(8'hA3, 1'b1);
    wait_status(32'h2, "rxA3_valid");
    pop_read(d);
    e = rxq.pop_front();
    check("rxA3_data", d, {24'b0, e});
    peek(A_ST, d);
    check("rxA3_popped", d, 32'h0);

    rxq.push_back(8'h11);
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    peek(A_ST, d);
    check("overrun_status", d, 32'h0A);
    pop_read(d);
    e = rxq.pop_front();
    check("overrun_keeps_first", d, {24'b0, e});
    bus_write(A_ST, 32'h8);
    peek(A_ST, d);
    check("overrun_cleared", d, 32'h0);

    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    peek(A_ST, d);
    check("false_start", d, 32'h0);

    send_rx(8'h3C, 1'b0);
    peek(A_ST, d);
    check("frame_err_set", d, 32'h4);
    bus_write(A_ST, 32'h4);
    peek(A_ST, d);
    check("frame_err_clr", d, 32'h0);

    rxq.push_back(8'h5A);
    fork
      send_rx(8'h5A, 1'b1);
      tx_frame(8'hC3, 1'b0, "txC3_conc");
    join
    wait_status(32'h2, "conc_rx_valid");
    pop_read(d);
    e = rxq.pop_front();
    check("conc_rx_data", d, {24'b0, e});

    rxq.push_back(8'h77);
    send_rx(8'h77, 1'b1);
    bus_write(A_TX, 32'h0F);
    repeat (50) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("rst_abort_tx", {31'b0, tx}, 32'd1);
    check("rst_abort_status", RD, 32'h0);
    peek(A_RX, d);
    check("rst_rxdata_clr", d, 32'h0);
    void'(rxq.pop_front());
    reset = 1'b1;
    tx_frame(8'h96, 1'b0, "tx96_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
